// File: rtl/serial_add_sequencer_if.sv
// serial_add_sequencer_if: start/busy handshake, operands and result bundle
interface serial_add_sequencer_if #(
    parameter int NUM_BITS = 8
);
    logic                start;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic                carry_in;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] sum;
    logic                carry_out;
    logic                overflow;
    modport master (output start, a, b, carry_in, input busy, done, sum, carry_out, overflow);
    modport slave (input start, a, b, carry_in, output busy, done, sum, carry_out, overflow);
endinterface

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial adder driving one adder_1bit cell, LSB first
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_add_sequencer #(
    parameter int NUM_BITS = 8
) (
    input logic clk,
    input logic rst,
    serial_add_sequencer_if.slave bus
);
    localparam int CW = $clog2(NUM_BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [NUM_BITS-1:0] shift_a_q, shift_a_d;
    logic [NUM_BITS-1:0] shift_b_q, shift_b_d;
    logic [NUM_BITS-1:0] acc_q, acc_d;
    logic                carry_q, carry_d;
    logic                msb_carry_q, msb_carry_d;
    logic                cell_sum, cell_carry;
    adder_1bit u_cell (
        .a         (shift_a_q[0]),
        .b         (shift_b_q[0]),
        .carry_in  (carry_q),
        .sum       (cell_sum),
        .carry_out (cell_carry)
    );
    // Result and carry registers hold their value from DONE until the next accepted start.
    assign bus.busy      = state_q == ADD;
    assign bus.done      = state_q == DONE;
    assign bus.sum       = acc_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = msb_carry_q ^ carry_q;
    // Next-state: load on accepted start, one bit per cycle in ADD, single DONE cycle.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_a_d   = shift_a_q;
        shift_b_d   = shift_b_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        msb_carry_d = msb_carry_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d     = ADD;
                shift_a_d   = bus.a;
                shift_b_d   = bus.b;
                carry_d     = bus.carry_in;
                count_d     = '0;
                acc_d       = '0;
                msb_carry_d = 1'b0;
            end
            ADD: begin
                acc_d     = {cell_sum, acc_q[NUM_BITS-1:1]};
                carry_d   = cell_carry;
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                count_d   = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d     = DONE;
                    msb_carry_d = carry_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            shift_a_q   <= '0;
            shift_b_q   <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            msb_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_a_q   <= shift_a_d;
            shift_b_q   <= shift_b_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            msb_carry_q <= msb_carry_d;
        end
    end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: random and directed checks of the serial adder at widths 8 and 32
module tb_serial_add_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int sel = 8;
    logic cur_busy, cur_done, cur_co, cur_ov;
    logic [31:0] cur_sum;
    logic [7:0] va [40];
    logic [7:0] vb [40];
    logic       vc [40];

    always #5 clk = ~clk;

    serial_add_sequencer_if #(.NUM_BITS(8))  i8 ();
    serial_add_sequencer_if #(.NUM_BITS(32)) i32 ();
    serial_add_sequencer #(.NUM_BITS(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
    serial_add_sequencer #(.NUM_BITS(32)) dut32 (.clk(clk), .rst(rst), .bus(i32));

    always_comb begin
        cur_busy = sel == 8 ? i8.busy : i32.busy;
        cur_done = sel == 8 ? i8.done : i32.done;
        cur_co   = sel == 8 ? i8.carry_out : i32.carry_out;
        cur_ov   = sel == 8 ? i8.overflow : i32.overflow;
        cur_sum  = sel == 8 ? {24'b0, i8.sum} : i32.sum;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (width %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    task automatic drive(input logic st, input logic [31:0] a, input logic [31:0] b, input logic ci);
        i8.start     = st && sel == 8;
        i8.a         = a[7:0];
        i8.b         = b[7:0];
        i8.carry_in  = ci;
        i32.start    = st && sel == 32;
        i32.a        = a;
        i32.b        = b;
        i32.carry_in = ci;
    endtask

    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci,
                                  output logic [31:0] s, output logic co, output logic ov);
        logic [32:0] m;
        logic [32:0] full;
        m    = (w == 32) ? 33'h0FFFFFFFF : (33'h1 << w) - 33'h1;
        full = ({1'b0, a} & m) + ({1'b0, b} & m) + {32'b0, ci};
        s    = full[31:0] & m[31:0];
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci);
        int nb = 0;
        int nd = 0;
        logic [31:0] es, gs;
        logic eco, eov, gco, gov;
        gs = 'x; gco = 1'bx; gov = 1'bx;
        model(sel, a, b, ci, es, eco, eov);
        drive(1'b1, a, b, ci);
        check("xz_in", 32'($isunknown(sel == 8 ? {i8.a, i8.b, i8.carry_in} : {i32.a[7:0], i32.b[7:0], i32.carry_in})), 0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, $urandom, $urandom, 1'($urandom));
        for (int k = 0; k < sel + 3; k++) begin
            if (cur_busy) nb++;
            if (cur_done) begin
                nd++;
                gs = cur_sum; gco = cur_co; gov = cur_ov;
            end
            drive(1'b0, $urandom, $urandom, 1'($urandom));
            @(negedge clk);
        end
        check("busy_cycles", nb, sel);
        check("done_pulses", nd, 1);
        check("sum", gs, es);
        check("carry_out", gco, eco);
        check("overflow", gov, eov);
        check("sum_hold", cur_sum, es);
    endtask

    initial begin
        int nd;
        logic [31:0] es;
        logic eco, eov;
        drive(1'b0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sel = 8;
        check("rst_busy", cur_busy, 0);
        check("rst_done", cur_done, 0);
        check("rst_sum", cur_sum, 0);
        check("rst_co", cur_co, 0);
        check("rst_ov", cur_ov, 0);
        run_op(32'h35, 32'h4A, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sum", cur_sum, 0);
        check("async_rst_co", cur_co, 0);
        check("async_rst_busy", cur_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hFF, 32'h01, 1'b1);
        run_op(32'h7F, 32'h01, 1'b0);
        run_op(32'h80, 32'h80, 1'b0);
        // start held high with operands changing every cycle
        for (int i = 0; i < 40; i++) begin
            check("b2b_done", cur_done, (i % 10) == 9);
            check("b2b_busy", cur_busy, (i % 10) >= 1 && (i % 10) <= 8);
            if ((i % 10) == 9) begin
                model(8, {24'b0, va[i-9]}, {24'b0, vb[i-9]}, vc[i-9], es, eco, eov);
                check("b2b_sum", cur_sum, es);
                check("b2b_co", cur_co, eco);
                check("b2b_ov", cur_ov, eov);
            end
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
            vc[i] = 1'($urandom);
            drive(i < 39, {24'b0, va[i]}, {24'b0, vb[i]}, vc[i]);
            @(negedge clk);
        end
        // reset while count==4 of an active addition
        drive(1'b1, 32'hAB, 32'hCD, 1'b1);
        @(posedge clk);
        drive(1'b0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", cur_busy, 0);
        check("abort_sum", cur_sum, 0);
        check("abort_done_now", cur_done, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (cur_done) nd++;
        end
        check("abort_no_done", nd, 0);
        run_op(32'h10, 32'h20, 1'b0);
        repeat (1000) run_op($urandom, $urandom, 1'($urandom));
        sel = 32;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
        run_op(32'h80000000, 32'h80000000, 1'b0);
        repeat (1000) run_op($urandom, $urandom, 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
